// File: rtl/thirty_two_bit_fast_adder.sv
// Three independent 32-bit adders (lookahead, skip, select) with registered
// results and a registered disagreement flag.
module thirty_two_bit_fast_adder #(
    parameter int GROUP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    input  logic        in_valid,
    output logic [31:0] cla_sum,
    output logic        cla_cout,
    output logic [31:0] cskip_sum,
    output logic        cskip_cout,
    output logic [31:0] cselect_sum,
    output logic        cselect_cout,
    output logic        out_valid,
    output logic        mismatch
);

    localparam int NB = 32 / GROUP;

    logic [31:0]   cla_g;
    logic [31:0]   cla_p;
    logic [31:0]   cla_c;
    logic [31:0]   cla_s;
    logic [NB-1:0] cla_bg;
    logic [NB-1:0] cla_bp;
    logic [NB:0]   cla_bc;
    logic          cla_t;

    always_comb begin
        cla_g  = a & b;
        cla_p  = a ^ b;
        cla_c  = '0;
        cla_bg = '0;
        cla_bp = '1;
        cla_bc = '0;
        cla_t  = 1'b0;
        // group generate/propagate per block
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                cla_t = cla_g[k*GROUP+i];
                for (int j = i + 1; j < GROUP; j++)
                    cla_t = cla_t & cla_p[k*GROUP+j];
                cla_bg[k] = cla_bg[k] | cla_t;
                cla_bp[k] = cla_bp[k] & cla_p[k*GROUP+i];
            end
        end
        // flat lookahead of every block carry-in from c0 and group terms
        for (int k = 0; k <= NB; k++) begin
            cla_t = c0;
            for (int j = 0; j < k; j++)
                cla_t = cla_t & cla_bp[j];
            cla_bc[k] = cla_t;
            for (int m = 0; m < k; m++) begin
                cla_t = cla_bg[m];
                for (int j = m + 1; j < k; j++)
                    cla_t = cla_t & cla_bp[j];
                cla_bc[k] = cla_bc[k] | cla_t;
            end
        end
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                cla_t = cla_bc[k];
                for (int j = 0; j < i; j++)
                    cla_t = cla_t & cla_p[k*GROUP+j];
                cla_c[k*GROUP+i] = cla_t;
                for (int m = 0; m < i; m++) begin
                    cla_t = cla_g[k*GROUP+m];
                    for (int j = m + 1; j < i; j++)
                        cla_t = cla_t & cla_p[k*GROUP+j];
                    cla_c[k*GROUP+i] = cla_c[k*GROUP+i] | cla_t;
                end
            end
        end
        cla_s = cla_p ^ cla_c;
    end

    logic [31:0] sk_s;
    logic [NB:0] sk_bc;
    logic        sk_r;
    logic        sk_all;

    always_comb begin
        sk_s     = '0;
        sk_bc    = '0;
        sk_bc[0] = c0;
        sk_r     = 1'b0;
        sk_all   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            sk_r   = sk_bc[k];
            sk_all = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                sk_s[k*GROUP+i] = a[k*GROUP+i] ^ b[k*GROUP+i] ^ sk_r;
                sk_r = (a[k*GROUP+i] & b[k*GROUP+i]) |
                       ((a[k*GROUP+i] ^ b[k*GROUP+i]) & sk_r);
                sk_all = sk_all & (a[k*GROUP+i] ^ b[k*GROUP+i]);
            end
            // a fully propagating block forwards its carry-in directly
            sk_bc[k+1] = sk_all ? sk_bc[k] : sk_r;
        end
    end

    logic [31:0]      sl_s;
    logic [NB:0]      sl_bc;
    logic             sl_r0;
    logic             sl_r1;
    logic [GROUP-1:0] sl_s0;
    logic [GROUP-1:0] sl_s1;

    always_comb begin
        sl_s     = '0;
        sl_bc    = '0;
        sl_bc[0] = c0;
        sl_r0    = 1'b0;
        sl_r1    = 1'b1;
        sl_s0    = '0;
        sl_s1    = '0;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) begin
                sl_r0 = c0;
                for (int i = 0; i < GROUP; i++) begin
                    sl_s[i] = a[i] ^ b[i] ^ sl_r0;
                    sl_r0 = (a[i] & b[i]) | ((a[i] ^ b[i]) & sl_r0);
                end
                sl_bc[1] = sl_r0;
            end else begin
                sl_r0 = 1'b0;
                sl_r1 = 1'b1;
                for (int i = 0; i < GROUP; i++) begin
                    sl_s0[i] = a[k*GROUP+i] ^ b[k*GROUP+i] ^ sl_r0;
                    sl_s1[i] = a[k*GROUP+i] ^ b[k*GROUP+i] ^ sl_r1;
                    sl_r0 = (a[k*GROUP+i] & b[k*GROUP+i]) |
                            ((a[k*GROUP+i] ^ b[k*GROUP+i]) & sl_r0);
                    sl_r1 = (a[k*GROUP+i] & b[k*GROUP+i]) |
                            ((a[k*GROUP+i] ^ b[k*GROUP+i]) & sl_r1);
                end
                sl_s[k*GROUP +: GROUP] = sl_bc[k] ? sl_s1 : sl_s0;
                sl_bc[k+1] = sl_bc[k] ? sl_r1 : sl_r0;
            end
        end
    end

    logic [32:0] cla_res;
    logic [32:0] sk_res;
    logic [32:0] sl_res;
    logic        differ;

    assign cla_res = {cla_bc[NB], cla_s};
    assign sk_res  = {sk_bc[NB], sk_s};
    assign sl_res  = {sl_bc[NB], sl_s};
    assign differ  = (cla_res != sk_res) || (cla_res != sl_res);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cla_sum      <= '0;
            cla_cout     <= 1'b0;
            cskip_sum    <= '0;
            cskip_cout   <= 1'b0;
            cselect_sum  <= '0;
            cselect_cout <= 1'b0;
            out_valid    <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {cla_cout, cla_sum}         <= cla_res;
                {cskip_cout, cskip_sum}     <= sk_res;
                {cselect_cout, cselect_sum} <= sl_res;
                mismatch                    <= differ;
            end
        end
    end

endmodule

// File: tb/tb_thirty_two_bit_fast_adder.sv
// Bench: GROUP=2,4,8 instances checked every cycle against an arithmetic model
// plus directed literal vectors.
module tb_thirty_two_bit_fast_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c0 = 1'b0;
    logic        in_valid = 1'b0;

    logic [31:0] cla_sum [3];
    logic        cla_cout [3];
    logic [31:0] cskip_sum [3];
    logic        cskip_cout [3];
    logic [31:0] cselect_sum [3];
    logic        cselect_cout [3];
    logic        out_valid [3];
    logic        mismatch [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    thirty_two_bit_fast_adder #(.GROUP(2)) u_g2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c0(c0), .in_valid(in_valid),
        .cla_sum(cla_sum[0]), .cla_cout(cla_cout[0]),
        .cskip_sum(cskip_sum[0]), .cskip_cout(cskip_cout[0]),
        .cselect_sum(cselect_sum[0]), .cselect_cout(cselect_cout[0]),
        .out_valid(out_valid[0]), .mismatch(mismatch[0])
    );

    thirty_two_bit_fast_adder #(.GROUP(4)) u_g4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c0(c0), .in_valid(in_valid),
        .cla_sum(cla_sum[1]), .cla_cout(cla_cout[1]),
        .cskip_sum(cskip_sum[1]), .cskip_cout(cskip_cout[1]),
        .cselect_sum(cselect_sum[1]), .cselect_cout(cselect_cout[1]),
        .out_valid(out_valid[1]), .mismatch(mismatch[1])
    );

    thirty_two_bit_fast_adder #(.GROUP(8)) u_g8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c0(c0), .in_valid(in_valid),
        .cla_sum(cla_sum[2]), .cla_cout(cla_cout[2]),
        .cskip_sum(cskip_sum[2]), .cskip_cout(cskip_cout[2]),
        .cselect_sum(cselect_sum[2]), .cselect_cout(cselect_cout[2]),
        .out_valid(out_valid[2]), .mismatch(mismatch[2])
    );

    // reference: plain 33-bit addition, captured on valid, cleared by reset
    logic [32:0] m_res;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res   <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid)
                m_res <= {1'b0, a} + {1'b0, b} + {32'd0, c0};
        end
    end

    task automatic check(input string name, input int d,
                         input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s g%0d got %h want %h at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [32:0] want,
                             input logic vld);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_cla"}, d, {cla_cout[d], cla_sum[d]}, want);
            check({tag, "_skip"}, d, {cskip_cout[d], cskip_sum[d]}, want);
            check({tag, "_sel"}, d, {cselect_cout[d], cselect_sum[d]}, want);
            check({tag, "_valid"}, d, {32'd0, out_valid[d]}, {32'd0, vld});
            check({tag, "_mism"}, d, {32'd0, mismatch[d]}, 33'd0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("cyc_cla", d, {cla_cout[d], cla_sum[d]}, m_res);
            check("cyc_skip", d, {cskip_cout[d], cskip_sum[d]}, m_res);
            check("cyc_sel", d, {cselect_cout[d], cselect_sum[d]}, m_res);
            check("cyc_valid", d, {32'd0, out_valid[d]}, {32'd0, m_valid});
            check("cyc_mism", d, {32'd0, mismatch[d]}, 33'd0);
        end
    end

    task automatic vec(input string tag, input logic [31:0] va,
                       input logic [31:0] vb, input logic vc,
                       input logic [32:0] want);
        @(negedge clk);
        #1;
        a = va;
        b = vb;
        c0 = vc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_model"}, 0, m_res, want);
        check_all(tag, want, 1'b1);
    endtask

    initial begin
        #1;
        check_all("rst0", 33'd0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        vec("v30_33", 32'd30, 32'd33, 1'b0, 33'd63);
        vec("v25_26", 32'd25, 32'd26, 1'b1, 33'd52);
        vec("prop_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
        vec("prop_mix", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 33'h1_0000_0000);
        vec("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        vec("half", 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);

        // hold while in_valid is low
        repeat (3) @(posedge clk);
        #1;
        check_all("hold", 33'h1_0000_0000, 1'b0);

        // asynchronous reset between edges
        vec("pre_rst", 32'd30, 32'd33, 1'b0, 33'd63);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 33'd0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("post_rst", 33'd0, 1'b0);

        // input present on the first edge after release is captured
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        a = 32'd1000;
        b = 32'd2345;
        c0 = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_all("release_cap", 33'd3346, 1'b1);

        // back-to-back random traffic, some with forced propagate patterns
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            #1;
            a = $urandom;
            b = (n % 7 == 3) ? ~a : $urandom;
            c0 = 1'($urandom_range(0, 1));
            in_valid = (n < 1500) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
